apb_req_bridge: RTL
===================

APB_REQ_BRIDGE -- requirements
Module: apb_req_bridge

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 1024, ACCESS-phase cycle limit (used only with APB_TIMEOUT_EN).
REQ-002 SHALL provide clock  input  1  sole clock, all flops on rising edge.
REQ-003 SHALL provide reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide req_valid  input  1  upstream request valid.
REQ-005 SHALL provide req_ready  output  1  bridge can accept request.
REQ-006 SHALL provide req_addr  input  32  byte address.
REQ-007 SHALL provide req_write  input  1  1=write, 0=read.
REQ-008 SHALL provide req_wdata  input  32  write data.
REQ-009 SHALL provide req_wstrb  input  4  write byte strobes.
REQ-010 SHALL provide rsp_valid  output  1  response valid.
REQ-011 SHALL provide rsp_ready  input  1  upstream accepts response.
REQ-012 SHALL provide rsp_rdata  output  32  read data (0 for writes).
REQ-013 SHALL provide rsp_err  output  1  slave error or timeout.
REQ-014 SHALL provide paddr  output  32  APB address.
REQ-015 SHALL provide psel  output  1  APB select.
REQ-016 SHALL provide penable  output  1  APB enable.
REQ-017 SHALL provide pprot  output  3  APB protection, constant 3'b000.
REQ-018 SHALL provide pwrite  output  1  APB direction.
REQ-019 SHALL provide pwdata  output  32  APB write data.
REQ-020 SHALL provide pstrb  output  4  APB strobes.
REQ-021 SHALL provide pready  input  1  APB slave ready (may be stretched by a downstream delayer).
REQ-022 SHALL provide prdata  input  32  APB read data.
REQ-023 SHALL provide pslverr  input  1  APB slave error.

Function
REQ-024 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-025 IDLE: on req_valid&&req_ready SHALL register addr/write/wdata/wstrb and go to SETUP next cycle.
REQ-026 SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
REQ-027 ACCESS: psel=1, penable=1 held until pready=1; paddr/pwrite/pwdata/pstrb stable through SETUP and ACCESS.
REQ-028 On pready in ACCESS SHALL register prdata (reads) or 0 (writes) into rsp_rdata and pslverr into rsp_err, go to RESP; psel/penable low that next cycle.
REQ-029 Reads SHALL drive pstrb=4'b0000 and pwdata=0; paddr passed unmodified, no alignment.
REQ-030 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on handshake go to IDLE next cycle.
REQ-031 Latency: accept at cycle N, pready=1 at N+2 -> rsp_valid at N+3; minimum accept-to-accept 4 cycles with rsp_ready=1.
REQ-032 All APB and rsp outputs SHALL be registered; no combinational path from pready/rsp_ready to outputs.
REQ-033 A new req_valid during SETUP/ACCESS/RESP SHALL be held off (req_ready=0), never dropped or merged.

Reset
REQ-034 reset_n low SHALL asynchronously force IDLE, all outputs 0 except req_ready=1 after release; in-flight APB transfer abandoned, no response issued.

Configuration
REQ-035 With APB_TIMEOUT_EN defined: cycle counter cleared on ACCESS entry, increments each ACCESS cycle with pready=0; after TIMEOUT such cycles SHALL end transfer as if pready=1 with rsp_rdata=0, rsp_err=1; pready on the limit cycle wins (normal completion).
REQ-036 Without APB_TIMEOUT_EN: counter not instantiated, TIMEOUT ignored, ACCESS waits indefinitely.

Verification
REQ-037 Read 0x1000_0004, pready=1 first ACCESS cycle, prdata=0xA5A5_5A5A -> rsp_valid at N+3, rsp_rdata=0xA5A5_5A5A, rsp_err=0, pstrb=0.
REQ-038 Write 0x1000_0008 wdata=0x1234_5678 wstrb=4'b0011, pready after 5 waits -> pwdata/pstrb stable 7 cycles, rsp_rdata=0, rsp_err=0.
REQ-039 Read with pslverr=1 at pready, rsp_ready low 3 cycles -> rsp_valid held 4 cycles, rsp_err=1, req_ready=0 throughout.
REQ-040 reset_n pulled low mid-ACCESS -> psel/penable/rsp_valid 0 immediately, next request handled normally.
REQ-041 APB_TIMEOUT_EN, TIMEOUT=8, pready never -> ACCESS 8 cycles, rsp_err=1, rsp_rdata=0; repeat with pready on 8th cycle -> rsp_err=0.

Source files
------------

// File: rtl/apb_req_bridge.sv
// Request/response to APB bridge: one transfer in flight, registered APB and response outputs.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_req_bridge #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic [2:0]  pprot,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic        pwrite_q, pwrite_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        timeout_s;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counts stalled ACCESS cycles; cleared in SETUP so it starts at zero on ACCESS entry
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = {CW{1'b0}};
    end else if (state_q == ACCESS && !pready) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= {CW{1'b0}};
    else          cnt_q <= cnt_d;
  end

  assign timeout_s = (state_q == ACCESS) && !pready && (cnt_q == LIMIT);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = SETUP;
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_write ? req_wdata : 32'h0000_0000;
          pstrb_d  = req_write ? req_wstrb : 4'b0000;
          psel_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // pready on the limit cycle takes priority over the watchdog
        if (pready || timeout_s) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (pready && !pwrite_q) ? prdata : 32'h0000_0000;
          rsp_err_d   = pready ? pslverr : 1'b1;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      paddr_q     <= 32'h0000_0000;
      pwdata_q    <= 32'h0000_0000;
      pstrb_q     <= 4'b0000;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pprot     = 3'b000;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;

endmodule
